// File: rtl/mdio_master_pkg.sv
// Shared state encoding, frame field codes and bit counts for the MDIO master.
package mdio_master_pkg;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, END} state_t;

  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  localparam logic [1:0] OP_C22_WR    = 2'b01;
  localparam logic [1:0] OP_C22_RD    = 2'b10;
  localparam logic [1:0] OP_C45_ADDR  = 2'b00;
  localparam logic [1:0] OP_C45_WR    = 2'b01;
  localparam logic [1:0] OP_C45_RDINC = 2'b10;
  localparam logic [1:0] OP_C45_RD    = 2'b11;

  localparam int HDR_BITS  = 14;
  localparam int DATA_BITS = 16;

  function automatic logic is_read(input logic c22, input logic [1:0] op);
    return c22 ? (op == OP_C22_RD) : ((op == OP_C45_RDINC) || (op == OP_C45_RD));
  endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC generator: half-period counter, mdc register and rise/fall strobes
// (strobes flag the clock edge at which mdc will toggle).
module mdio_mdc_gen #(
  parameter int MDC_DIV = 80
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic en_i,
  output logic mdc_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int HALF = MDC_DIV / 2;
  localparam int CW   = $clog2(HALF);

  logic [CW-1:0] cnt_q;
  logic          mdc_q;
  logic          tc;

  assign tc     = en_i && (cnt_q == CW'(HALF - 1));
  assign rise_o = tc && !mdc_q;
  assign fall_o = tc && mdc_q;
  assign mdc_o  = mdc_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i || !en_i) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (tc) begin
      cnt_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// MDIO master: one Clause 22/45 management frame per accepted command.
// Optional preamble suppression input under MDIO_MASTER_PRE_SUPPRESS_EN.
module mdio_master
  import mdio_master_pkg::*;
#(
  parameter int MDC_DIV = 80,
  parameter int PRE_LEN = 32
) (
  input  logic        clk_200m,
  input  logic        rstn_200m,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_st,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  input  logic        opendrain_mode,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_ta_err,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oen,
`ifdef MDIO_MASTER_PRE_SUPPRESS_EN
  input  logic        cmd_pre_sup,
`endif
  input  logic        mdio_in
);

  localparam int BCW = (PRE_LEN > 16) ? $clog2(PRE_LEN) : 4;
  localparam logic [1:0] REL = 2'b11;

  state_t                state_q;
  logic [BCW-1:0]        bcnt_q;
  logic [HDR_BITS-1:0]   hdr_q, hdr_w;
  logic [DATA_BITS-1:0]  wd_q, rx_q, rsp_rdata_q;
  logic                  rd_q, ta_q, sync1_q, sync2_q;
  logic                  mdio_out_q, mdio_oen_q, rsp_valid_q, rsp_ta_err_q;
  logic                  mdc_rise, mdc_fall, pre_sup;

`ifdef MDIO_MASTER_PRE_SUPPRESS_EN
  assign pre_sup = cmd_pre_sup;
`else
  assign pre_sup = 1'b0;
`endif

  assign hdr_w      = {cmd_st ? ST_C22 : ST_C45, cmd_op, cmd_phyad, cmd_regad};
  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_ta_err = rsp_ta_err_q;
  assign mdio_out   = mdio_out_q;
  assign mdio_oen   = mdio_oen_q;

  mdio_mdc_gen #(.MDC_DIV(MDC_DIV)) u_mdc (
    .clk_i  (clk_200m),
    .rstn_i (rstn_200m),
    .en_i   (state_q != IDLE),
    .mdc_o  (mdc),
    .rise_o (mdc_rise),
    .fall_o (mdc_fall)
  );

  // {out, oen}: open-drain releases the line for '1' bits
  function automatic logic [1:0] drv(input logic b, input logic od);
    return {b, od ? b : 1'b0};
  endfunction

  always_ff @(posedge clk_200m) begin
    if (!rstn_200m) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= mdio_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_200m) begin
    if (!rstn_200m) begin
      state_q                  <= IDLE;
      bcnt_q                   <= '0;
      hdr_q                    <= '0;
      wd_q                     <= '0;
      rx_q                     <= '0;
      rd_q                     <= 1'b0;
      ta_q                     <= 1'b0;
      {mdio_out_q, mdio_oen_q} <= REL;
      rsp_valid_q              <= 1'b0;
      rsp_rdata_q              <= '0;
      rsp_ta_err_q             <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (mdc_rise) begin
        if (state_q == TA && bcnt_q == BCW'(1)) ta_q <= sync2_q;
        if (state_q == DATA) rx_q <= {rx_q[DATA_BITS-2:0], sync2_q};
      end
      case (state_q)
        IDLE: if (cmd_valid) begin
          rd_q   <= is_read(cmd_st, cmd_op);
          wd_q   <= cmd_wdata;
          bcnt_q <= '0;
          if (pre_sup) begin
            state_q                  <= HDR;
            {mdio_out_q, mdio_oen_q} <= drv(hdr_w[HDR_BITS-1], opendrain_mode);
            hdr_q                    <= hdr_w << 1;
          end else begin
            state_q                  <= PRE;
            {mdio_out_q, mdio_oen_q} <= drv(1'b1, opendrain_mode);
            hdr_q                    <= hdr_w;
          end
        end
        PRE: if (mdc_fall) begin
          if (bcnt_q == BCW'(PRE_LEN - 1)) begin
            state_q                  <= HDR;
            bcnt_q                   <= '0;
            {mdio_out_q, mdio_oen_q} <= drv(hdr_q[HDR_BITS-1], opendrain_mode);
            hdr_q                    <= hdr_q << 1;
          end else begin
            bcnt_q                   <= bcnt_q + 1'b1;
            {mdio_out_q, mdio_oen_q} <= drv(1'b1, opendrain_mode);
          end
        end
        HDR: if (mdc_fall) begin
          if (bcnt_q == BCW'(HDR_BITS - 1)) begin
            state_q                  <= TA;
            bcnt_q                   <= '0;
            {mdio_out_q, mdio_oen_q} <= rd_q ? REL : drv(1'b1, opendrain_mode);
          end else begin
            bcnt_q                   <= bcnt_q + 1'b1;
            {mdio_out_q, mdio_oen_q} <= drv(hdr_q[HDR_BITS-1], opendrain_mode);
            hdr_q                    <= hdr_q << 1;
          end
        end
        TA: if (mdc_fall) begin
          if (bcnt_q == '0) begin
            bcnt_q                   <= BCW'(1);
            {mdio_out_q, mdio_oen_q} <= rd_q ? REL : drv(1'b0, opendrain_mode);
          end else begin
            state_q                  <= DATA;
            bcnt_q                   <= '0;
            {mdio_out_q, mdio_oen_q} <= rd_q ? REL : drv(wd_q[DATA_BITS-1], opendrain_mode);
            wd_q                     <= wd_q << 1;
          end
        end
        DATA: if (mdc_fall) begin
          if (bcnt_q == BCW'(DATA_BITS - 1)) begin
            state_q                  <= END;
            {mdio_out_q, mdio_oen_q} <= REL;
          end else begin
            bcnt_q                   <= bcnt_q + 1'b1;
            {mdio_out_q, mdio_oen_q} <= rd_q ? REL : drv(wd_q[DATA_BITS-1], opendrain_mode);
            wd_q                     <= wd_q << 1;
          end
        end
        END: if (mdc_fall) begin
          state_q      <= IDLE;
          rsp_valid_q  <= 1'b1;
          rsp_rdata_q  <= rd_q ? rx_q : '0;
          rsp_ta_err_q <= rd_q & ta_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
